// File: rtl/bcm_scan_pkg.sv
// Shared types and helpers for the BCM scan sequencer.
//   scan_state_e    : sequencer FSM states
//   *_DEF           : default configuration (64x32 HUB75, 6 bit-planes)
//   PLANE_BITS      : plane counter width for the default configuration
//   COL_BITS        : column counter width for the default configuration
//   plane_bits()    : plane counter width for any plane count (min 1)
//   col_bits()      : column counter width for any column count (min 1)
//   oe_weight()     : OE on-time of a bit-plane, OE_UNIT << plane
package bcm_scan_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      WAIT_OE = 2'd2,
      LATCH   = 2'd3
   } scan_state_e;

   localparam int unsigned COLUMNS_DEF  = 64;
   localparam int unsigned ROW_BITS_DEF = 4;
   localparam int unsigned PLANES_DEF   = 6;
   localparam int unsigned OE_UNIT_DEF  = 1;

   localparam int unsigned PLANE_BITS = $clog2(PLANES_DEF);
   localparam int unsigned COL_BITS   = $clog2(COLUMNS_DEF);

   function automatic int unsigned plane_bits(input int unsigned planes);
      return (planes > 1) ? $clog2(planes) : 1;
   endfunction

   function automatic int unsigned col_bits(input int unsigned columns);
      return (columns > 1) ? $clog2(columns) : 1;
   endfunction

   // Binary weight of a bit-plane in oscillator clocks.
   function automatic int unsigned oe_weight(input int unsigned oe_unit,
                                             input int unsigned plane);
      return oe_unit << plane;
   endfunction

endpackage

// File: rtl/bcm_oe_timer.sv
// Loadable down-counter timing the output-enable window of the latched plane.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   load       : load load_value this cycle (wins over decrement)
//   load_value : new on-time in clocks
//   count      : current remaining on-time (registered)
//   zero       : count == 0 (registered)
module bcm_oe_timer #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             zero_q, zero_d;

   // Decrement saturates at zero; a load restarts the window.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
      zero_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= zero_d;
      end
   end

   assign count = count_q;
   assign zero  = zero_q;

endmodule

// File: rtl/bcm_scan_sequencer.sv
// HUB75 scan sequencer with binary-code-modulation bit-plane timing.
// The next bit-plane is shifted while the previously latched one is shown.
// Optional macro BCM_SCAN_DIM_EN adds a global dim input (OE >> dim, min 1).
//   clk_in             : root clock
//   reset              : asynchronous active-low reset
//   dim                : (BCM_SCAN_DIM_EN only) on-time right shift, sampled at latch
//   enable             : run request, honoured at plane boundaries
//   column_address     : column being shifted
//   row_address        : row being shifted
//   row_address_active : row latched / on display
//   brightness_mask    : one-hot plane being shifted
//   clk_pixel          : shift clock, panel samples on rising edge
//   row_latch          : one-cycle latch strobe
//   output_enable      : active-high display enable
//   frame_start        : pulse at the row 0 / plane 0 latch
//   busy               : sequencer running or display window still open
module bcm_scan_sequencer
   import bcm_scan_pkg::*;
#(
   parameter  int unsigned COLUMNS  = COLUMNS_DEF,
   parameter  int unsigned ROW_BITS = ROW_BITS_DEF,
   parameter  int unsigned PLANES   = PLANES_DEF,
   parameter  int unsigned OE_UNIT  = OE_UNIT_DEF,
   localparam int unsigned COL_W    = col_bits(COLUMNS),
   localparam int unsigned PLANE_W  = plane_bits(PLANES)
) (
   input  logic                clk_in,
   input  logic                reset,
`ifdef BCM_SCAN_DIM_EN
   input  logic [2:0]          dim,
`endif
   input  logic                enable,
   output logic [COL_W-1:0]    column_address,
   output logic [ROW_BITS-1:0] row_address,
   output logic [ROW_BITS-1:0] row_address_active,
   output logic [PLANES-1:0]   brightness_mask,
   output logic                clk_pixel,
   output logic                row_latch,
   output logic                output_enable,
   output logic                frame_start,
   output logic                busy
);

   localparam int unsigned TIMER_W = $clog2(OE_UNIT * (2 ** (PLANES - 1))) + 1;

   scan_state_e         state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [ROW_BITS-1:0] row_active_q, row_active_d;
   logic [PLANE_W-1:0]  plane_q, plane_d;
   logic [PLANES-1:0]   mask_q, mask_d;
   logic                pix_q, pix_d;
   logic                latch_q, latch_d;
   logic                oe_q, oe_d;
   logic                frame_q, frame_d;
   logic                busy_q, busy_d;

   int unsigned         weight_c;
   logic                timer_load_c;
   logic [TIMER_W-1:0]  timer_load_value_c;
   logic [TIMER_W-1:0]  timer_count;
   logic                timer_zero;
   logic                timer_next_zero_c;

   // On-time of the plane being latched, optionally dimmed.
   always_comb begin
      weight_c = oe_weight(OE_UNIT, 32'(plane_q));
`ifdef BCM_SCAN_DIM_EN
      weight_c = weight_c >> dim;
      if (weight_c == 0) begin
         weight_c = 1;
      end
`endif
      timer_load_value_c = TIMER_W'(weight_c);
   end

   assign timer_load_c = (state_q == LATCH);

   // Timer value after this edge is zero; a load is always nonzero.
   assign timer_next_zero_c = !timer_load_c &&
                              (timer_zero || (timer_count == TIMER_W'(1)));

   bcm_oe_timer #(
      .WIDTH (TIMER_W)
   ) u_oe_timer (
      .clk        (clk_in),
      .rst_n      (reset),
      .load       (timer_load_c),
      .load_value (timer_load_value_c),
      .count      (timer_count),
      .zero       (timer_zero)
   );

   // Next state, counters, and registered output values.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      plane_d      = plane_q;
      row_active_d = row_active_q;
      pix_d        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!pix_q) begin
               pix_d = 1'b1;
            end else if (col_q == COL_W'(COLUMNS - 1)) begin
               col_d   = '0;
               // Skip WAIT_OE when the window closes on this same edge.
               state_d = timer_next_zero_c ? LATCH : WAIT_OE;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         WAIT_OE: begin
            if (timer_next_zero_c) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            if (plane_q == PLANE_W'(PLANES - 1)) begin
               plane_d = '0;
               row_d   = row_q + 1'b1;
            end else begin
               plane_d = plane_q + 1'b1;
            end
            state_d = enable ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase

      latch_d = (state_d == LATCH);
      frame_d = latch_d && (row_q == '0) && (plane_q == '0);
      if (latch_d) begin
         row_active_d = row_q;
      end
      oe_d   = !timer_next_zero_c && !latch_d;
      busy_d = (state_d != IDLE) || !timer_next_zero_c;
      mask_d = PLANES'(1) << plane_d;
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         row_active_q <= '0;
         plane_q      <= '0;
         mask_q       <= PLANES'(1);
         pix_q        <= 1'b0;
         latch_q      <= 1'b0;
         oe_q         <= 1'b0;
         frame_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         row_active_q <= row_active_d;
         plane_q      <= plane_d;
         mask_q       <= mask_d;
         pix_q        <= pix_d;
         latch_q      <= latch_d;
         oe_q         <= oe_d;
         frame_q      <= frame_d;
         busy_q       <= busy_d;
      end
   end

   assign column_address     = col_q;
   assign row_address        = row_q;
   assign row_address_active = row_active_q;
   assign brightness_mask    = mask_q;
   assign clk_pixel          = pix_q;
   assign row_latch          = latch_q;
   assign output_enable      = oe_q;
   assign frame_start        = frame_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_bcm_scan_sequencer.sv
// Directed bench for bcm_scan_sequencer: default build plus an OE_UNIT = 8 instance.
module tb_bcm_scan_sequencer;

   logic       clk;
   logic       rst0_n, en0, rst8_n, en8;
   logic [2:0] dim0, dim8;
   logic [5:0] col0, col8, mask0, mask8;
   logic [3:0] row0, row8, rowa0, rowa8;
   logic       pix0, lat0, oe0, fs0, busy0;
   logic       pix8, lat8, oe8, fs8, busy8;
   logic       sel;
   logic       lat_s, oe_s, pix_s;

   int checks = 0;
   int errors = 0;

   bcm_scan_sequencer u_dut0 (
      .clk_in             (clk),
      .reset              (rst0_n),
`ifdef BCM_SCAN_DIM_EN
      .dim                (dim0),
`endif
      .enable             (en0),
      .column_address     (col0),
      .row_address        (row0),
      .row_address_active (rowa0),
      .brightness_mask    (mask0),
      .clk_pixel          (pix0),
      .row_latch          (lat0),
      .output_enable      (oe0),
      .frame_start        (fs0),
      .busy               (busy0)
   );

   bcm_scan_sequencer #(.OE_UNIT(8)) u_dut8 (
      .clk_in             (clk),
      .reset              (rst8_n),
`ifdef BCM_SCAN_DIM_EN
      .dim                (dim8),
`endif
      .enable             (en8),
      .column_address     (col8),
      .row_address        (row8),
      .row_address_active (rowa8),
      .brightness_mask    (mask8),
      .clk_pixel          (pix8),
      .row_latch          (lat8),
      .output_enable      (oe8),
      .frame_start        (fs8),
      .busy               (busy8)
   );

   assign lat_s = sel ? lat8 : lat0;
   assign oe_s  = sel ? oe8  : oe0;
   assign pix_s = sel ? pix8 : pix0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clocks until the selected DUT strobes row_latch, with OE / pixel-clock high counts.
   task automatic wait_latch(output int cycles, output int oe_cnt, output int pix_cnt);
      cycles  = 0;
      oe_cnt  = 0;
      pix_cnt = 0;
      do begin
         tick();
         cycles++;
         if (oe_s)  oe_cnt++;
         if (pix_s) pix_cnt++;
      end while (!lat_s && cycles < 600);
      check("latch_seen", int'(lat_s), 1);
   endtask

   int n, o, p, hits;
   int dim_oe[6] = '{1, 1, 1, 1, 2, 4};

   initial begin
      rst0_n = 1'b1; rst8_n = 1'b1;
      en0 = 1'b0; en8 = 1'b0; sel = 1'b0;
      dim0 = 3'd0; dim8 = 3'd0;
      #2;
      rst0_n = 1'b0; rst8_n = 1'b0;
      #10;

      // Reset state
      check("rst_col",   int'(col0),  0);
      check("rst_row",   int'(row0),  0);
      check("rst_rowa",  int'(rowa0), 0);
      check("rst_mask",  int'(mask0), 1);
      check("rst_pix",   int'(pix0),  0);
      check("rst_latch", int'(lat0),  0);
      check("rst_oe",    int'(oe0),   0);
      check("rst_fs",    int'(fs0),   0);
      check("rst_busy",  int'(busy0), 0);

      // First latch: IDLE cycle + 128 shift cycles, latch on the 130th cycle
      tick();
      rst0_n = 1'b1;
      en0    = 1'b1;
      wait_latch(n, o, p);
      check("first_latch_dist", n, 129);
      check("first_fs",    int'(fs0),   1);
      check("first_rowa",  int'(rowa0), 0);
      check("first_mask",  int'(mask0), 1);
      check("first_pix",   p, 64);

      // Free run through one full frame of 16 rows x 6 planes
      for (int k = 1; k <= 96; k++) begin
         wait_latch(n, o, p);
         check("run_spacing", n, 129);
         check("run_oe",      o, 1 << ((k - 1) % 6));
         check("run_pix",     p, 64);
         check("run_mask",    int'(mask0), 1 << (k % 6));
         check("run_rowa",    int'(rowa0), (k / 6) % 16);
         check("run_fs",      int'(fs0),   (k % 96 == 0) ? 1 : 0);
      end

      // Advance to the latch of row 3 plane 1
      for (int k = 0; k < 19; k++) begin
         wait_latch(n, o, p);
      end
      check("pre_drop_rowa", int'(rowa0), 3);
      check("pre_drop_mask", int'(mask0), 2);

      // Drop enable mid-shift of row 3 plane 2
      for (int k = 0; k < 50; k++) tick();
      en0 = 1'b0;
      wait_latch(n, o, p);
      check("drop_latch_dist", n, 79);
      check("drop_rowa", int'(rowa0), 3);
      check("drop_mask", int'(mask0), 4);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("drop_oe_on",   int'(oe0),   1);
         check("drop_busy_on", int'(busy0), 1);
      end
      tick();
      check("drop_oe_off",   int'(oe0),   0);
      check("drop_busy_off", int'(busy0), 0);
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (lat0 || pix0 || busy0) hits++;
      end
      check("idle_quiet", hits, 0);
      check("idle_row",   int'(row0),  3);
      check("idle_mask",  int'(mask0), 8);

      // Re-enable resumes at row 3 plane 3
      en0 = 1'b1;
      tick();
      check("resume_pix0", int'(pix0), 0);
      check("resume_col0", int'(col0), 0);
      check("resume_busy", int'(busy0), 1);
      tick();
      check("resume_pix1", int'(pix0), 1);
      check("resume_col1", int'(col0), 0);
      tick();
      check("resume_pix2", int'(pix0), 0);
      check("resume_col2", int'(col0), 1);
      wait_latch(n, o, p);
      check("resume_dist", n, 126);
      check("resume_oe",   o, 0);
      check("resume_pixc", p, 63);
      check("resume_rowa", int'(rowa0), 3);
      check("resume_mask", int'(mask0), 8);

      // Asynchronous reset mid-shift
      for (int k = 0; k < 40; k++) tick();
      #2;
      rst0_n = 1'b0;
      #1;
      check("arst_col",   int'(col0),  0);
      check("arst_row",   int'(row0),  0);
      check("arst_rowa",  int'(rowa0), 0);
      check("arst_mask",  int'(mask0), 1);
      check("arst_pix",   int'(pix0),  0);
      check("arst_latch", int'(lat0),  0);
      check("arst_oe",    int'(oe0),   0);
      check("arst_fs",    int'(fs0),   0);
      check("arst_busy",  int'(busy0), 0);
      tick();
      rst0_n = 1'b1;
      wait_latch(n, o, p);
      check("post_rst_dist", n, 129);
      check("post_rst_rowa", int'(rowa0), 0);
      check("post_rst_mask", int'(mask0), 1);
      check("post_rst_fs",   int'(fs0),   1);

      // OE_UNIT = 8: plane 5 window stretches its period to 257 clocks
      sel    = 1'b1;
      rst8_n = 1'b1;
      en8    = 1'b1;
      wait_latch(n, o, p);
      check("u8_first_dist", n, 129);
      for (int k = 1; k <= 6; k++) begin
         wait_latch(n, o, p);
         check("u8_spacing", n, (k == 6) ? 257 : 129);
         check("u8_oe",      o, 8 << (k - 1));
         check("u8_pix",     p, 64);
      end
      check("u8_rowa", int'(rowa8), 1);

`ifdef BCM_SCAN_DIM_EN
      // Global dimming by 3 on the default instance
      sel    = 1'b0;
      rst0_n = 1'b0;
      tick();
      dim0   = 3'd3;
      rst0_n = 1'b1;
      wait_latch(n, o, p);
      check("dim_first_dist", n, 129);
      for (int k = 1; k <= 6; k++) begin
         wait_latch(n, o, p);
         check("dim_oe", o, dim_oe[k - 1]);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcm_scan_sequencer.md
Name: bcm_scan_sequencer

Overview:
Scan sequencer for the HUB75-style 64x32 matrix, driven by the on-chip oscillator clock. Drives column/row addressing, pixel clock, latch and output-enable with binary-code-modulation (BCM) bit-plane timing. Shifting the next bit-plane overlaps with displaying the latched one. Colour sources use column_address, row_address and brightness_mask to produce rgb1/rgb2 for the shift.

Parameters:
COLUMNS, 64, pixels shifted per row per plane.
ROW_BITS, 4, row address width; rows scanned = 2**ROW_BITS.
PLANES, 6, colour depth in bit-planes; plane b weight = 2**b.
OE_UNIT, 1, clocks of OE on-time per LSB weight unit (>=1).

Ports:
clk_in  in  1  root clock.
reset  in  1  asynchronous, active-low reset.
enable  in  1  run request; low parks the sequencer at the next plane boundary.
column_address  out  $clog2(COLUMNS)  column being shifted.
row_address  out  ROW_BITS  row being shifted.
row_address_active  out  ROW_BITS  row currently latched/displayed (drives A-D).
brightness_mask  out  PLANES  one-hot plane being shifted.
clk_pixel  out  1  shift clock; data changes while low, panel samples on rising edge.
row_latch  out  1  one-cycle latch strobe.
output_enable  out  1  active-high display enable; inverted at the pins.
frame_start  out  1  one-cycle pulse at row 0, plane 0 latch.
busy  out  1  high whenever state != IDLE or OE timer nonzero.

Behaviour:
- Reset (async, any time, including mid-shift): all outputs 0, brightness_mask = 1, state IDLE, plane/row/column counters 0, OE timer 0.
- States: IDLE, SHIFT, WAIT_OE, LATCH.
- IDLE: if enable, go to SHIFT next cycle; otherwise stay.
- SHIFT: 2 clocks per column. Phase 0: clk_pixel = 0, column_address valid. Phase 1: clk_pixel = 1. After column COLUMNS-1, phase 1: column_address wraps to 0. Go to WAIT_OE, or straight to LATCH if the OE timer is 0. Duration is exactly 2*COLUMNS cycles.
- WAIT_OE: hold with clk_pixel = 0 until the OE timer reaches 0, then go to LATCH.
- LATCH, exactly 1 cycle:
  - row_latch = 1 and output_enable = 0.
  - row_address_active <= row_address.
  - OE timer loads OE_UNIT << plane.
  - frame_start = 1 if row = 0 and plane = 0.
  - Plane advances LSB to MSB. After plane PLANES-1: plane goes to 0 and row increments. Row wraps from 2**ROW_BITS-1 to 0.
  - Next state is SHIFT if enable, else IDLE.
- OE timer: output_enable = (timer != 0) and state != LATCH. Decrements by 1 per cycle while nonzero. Independent of state, so the latched plane always gets its full weight even after enable drops.
- Display time for plane b is exactly OE_UNIT*2**b cycles. Plane period is max(2*COLUMNS, OE_UNIT*2**b) + 1 cycles.
- enable is sampled only in IDLE and LATCH. A drop mid-SHIFT completes that shift and latch. Re-enable resumes at the stored plane/row position.
- Simultaneous timer expiry and SHIFT completion: go to LATCH directly; no WAIT_OE cycle.

Optional Feature:
Macro: BCM_SCAN_DIM_EN.
- Defined: adds input dim [2:0]. OE load value = (OE_UNIT << plane) >> dim, floored at 1 clock. Gives global dimming without touching colour data. dim is sampled at LATCH.
- Undefined: no dim port; full on-time as above.

Decomposition:
- Package bcm_scan_pkg:
  - state enum (IDLE, SHIFT, WAIT_OE, LATCH).
  - PLANE_BITS = $clog2(PLANES).
  - Column width localparam.
  - Weight function OE_UNIT << plane.
- Sub-module bcm_oe_timer: loadable down-counter with a zero flag. Width = $clog2(OE_UNIT*2**(PLANES-1)) + 1.

Test Plan:
- Reset release with enable = 1, default parameters: first row_latch at cycle 130 after leaving IDLE. frame_start coincides with it. Afterwards, row_address_active = 0 and output_enable high for 1 cycle.
- Default parameters, free run: latch spacing is 129 cycles for every plane. Per plane b, OE high count is 1, 2, 4, 8, 16, 32. row_address_active steps 0..15 and wraps; frame_start repeats every 16*6*129 cycles.
- OE_UNIT = 8: plane 5 OE = 256 cycles. WAIT_OE is held for 128 cycles, so the next latch comes 257 cycles later; clk_pixel stays 0 during the stall.
- enable dropped mid-SHIFT of row 3, plane 2: the shift and latch complete, then IDLE. OE stays high for the full 4 cycles, then 0 and busy = 0. Re-enable: the next latch shows row 3, plane 3.
- Reset asserted mid-SHIFT: all outputs 0 the same cycle, without waiting for a clock edge. After release, the next latch is row 0, plane 0.
- BCM_SCAN_DIM_EN with dim = 3, default parameters: OE counts per plane are 1, 1, 1, 1, 2, 4.
